// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared encodings, FSM state type and RAM limit for the memory initiator
package cpu_mem_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [15:0] ADDR_LIMIT_DEFAULT = 16'h0800;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: data-priority arbiter that yields to a pending fetch after a data grant
module mem_arbiter (
  input  logic if_req,
  input  logic d_req,
  input  logic last_d,
  output logic gnt_v,
  output logic gnt_d
);
  assign gnt_v = if_req | d_req;
  assign gnt_d = d_req & ~(last_d & if_req);
endmodule

// File: rtl/mem_initiator.sv
// mem_initiator: arbitrates fetch and data ports onto a single-port RAM with 3-cycle accesses
module mem_initiator
  import cpu_mem_pkg::*;
#(
  parameter logic [15:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_if_req,
  input  logic [15:0] I_if_addr,
  output logic        O_if_ack,
  output logic [15:0] O_if_data,
  output logic        O_if_err,
  input  logic        I_d_req,
  input  logic        I_d_write,
  input  logic [1:0]  I_d_size,
  input  logic        I_d_signed,
  input  logic [15:0] I_d_addr,
  input  logic [15:0] I_d_wdata,
  output logic        O_d_ack,
  output logic [15:0] O_d_rdata,
  output logic        O_d_err,
  output logic        O_ram_enable,
  output logic        O_ram_write,
  output logic [1:0]  O_ram_size,
  output logic [15:0] O_ram_addr,
  output logic [15:0] O_ram_data,
  input  logic [15:0] I_ram_data
);
  state_t state;
  logic last_d, cur_d, cur_err, cur_signed;
  logic gnt_v, gnt_d, d_bad, if_bad, req_err;
  logic [15:0] load_data;
  mem_arbiter u_arb (
    .if_req(I_if_req & ~O_if_ack),
    .d_req (I_d_req & ~O_d_ack),
    .last_d(last_d),
    .gnt_v (gnt_v),
    .gnt_d (gnt_d)
  );
  assign d_bad = (I_d_addr >= ADDR_LIMIT) || (I_d_size != SIZE_BYTE && I_d_size != SIZE_WORD);
  assign if_bad = I_if_addr >= ADDR_LIMIT;
  assign req_err = gnt_d ? d_bad : if_bad;
  assign load_data = (O_ram_size == SIZE_BYTE) ? {{8{cur_signed & I_ram_data[7]}}, I_ram_data[7:0]} : I_ram_data;
  // RAM-side registers keep the granted request's attributes for the capture step
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state        <= IDLE;
      last_d       <= 1'b0;
      cur_d        <= 1'b0;
      cur_err      <= 1'b0;
      cur_signed   <= 1'b0;
      O_if_ack     <= 1'b0;
      O_if_data    <= 16'h0;
      O_if_err     <= 1'b0;
      O_d_ack      <= 1'b0;
      O_d_rdata    <= 16'h0;
      O_d_err      <= 1'b0;
      O_ram_enable <= 1'b0;
      O_ram_write  <= 1'b0;
      O_ram_size   <= 2'd0;
      O_ram_addr   <= 16'h0;
      O_ram_data   <= 16'h0;
    end else begin
      O_if_ack <= 1'b0;
      O_if_err <= 1'b0;
      O_d_ack  <= 1'b0;
      O_d_err  <= 1'b0;
      case (state)
        IDLE: if (gnt_v) begin
          cur_d        <= gnt_d;
          last_d       <= gnt_d;
          cur_err      <= req_err;
          cur_signed   <= I_d_signed;
          O_ram_enable <= ~req_err;
          O_ram_write  <= gnt_d & I_d_write;
          O_ram_size   <= gnt_d ? I_d_size : SIZE_WORD;
          O_ram_addr   <= gnt_d ? I_d_addr : I_if_addr;
          O_ram_data   <= gnt_d ? I_d_wdata : 16'h0;
          state        <= ISSUE;
        end
        ISSUE: begin
          O_ram_enable <= 1'b0;
          state        <= CAPTURE;
        end
        CAPTURE: begin
          if (cur_d) begin
            O_d_ack <= 1'b1;
            O_d_err <= cur_err;
            if (cur_err) O_d_rdata <= 16'h0;
            else if (!O_ram_write) O_d_rdata <= load_data;
          end else begin
            O_if_ack  <= 1'b1;
            O_if_err  <= cur_err;
            O_if_data <= cur_err ? 16'h0 : I_ram_data;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: scoreboard bench with a byte-addressed RAM model behind the initiator
module tb_mem_initiator;
  logic I_clk = 1'b0, I_reset_n = 1'b0;
  logic I_if_req = 1'b0, I_d_req = 1'b0, I_d_write = 1'b0, I_d_signed = 1'b0;
  logic [1:0] I_d_size = 2'd0;
  logic [15:0] I_if_addr = 16'h0, I_d_addr = 16'h0, I_d_wdata = 16'h0, I_ram_data = 16'h0;
  logic O_if_ack, O_if_err, O_d_ack, O_d_err, O_ram_enable, O_ram_write;
  logic [15:0] O_if_data, O_d_rdata, O_ram_addr, O_ram_data;
  logic [1:0] O_ram_size;
  mem_initiator dut (
    .I_clk(I_clk), .I_reset_n(I_reset_n),
    .I_if_req(I_if_req), .I_if_addr(I_if_addr),
    .O_if_ack(O_if_ack), .O_if_data(O_if_data), .O_if_err(O_if_err),
    .I_d_req(I_d_req), .I_d_write(I_d_write), .I_d_size(I_d_size), .I_d_signed(I_d_signed),
    .I_d_addr(I_d_addr), .I_d_wdata(I_d_wdata),
    .O_d_ack(O_d_ack), .O_d_rdata(O_d_rdata), .O_d_err(O_d_err),
    .O_ram_enable(O_ram_enable), .O_ram_write(O_ram_write), .O_ram_size(O_ram_size),
    .O_ram_addr(O_ram_addr), .O_ram_data(O_ram_data), .I_ram_data(I_ram_data)
  );
  always #5 I_clk = ~I_clk;
  int cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;
  logic [7:0] mem [0:2047];
  logic [10:0] ai;
  bit loaded = 0, en_prev = 0;
  int en_count = 0, b2b = 0;
  // RAM model: little-endian byte array, registered read data, byte reads zero-extended
  always @(posedge I_clk) begin
    if (!loaded) begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
      mem[0] = 8'h00;
      mem[1] = 8'h80;
      mem[2047] = 8'h7E;
      loaded = 1;
    end
    ai = O_ram_addr[10:0];
    if (O_ram_enable) begin
      en_count++;
      if (en_prev) b2b++;
      if (O_ram_write) begin
        mem[ai] = O_ram_data[7:0];
        if (O_ram_size == 2'd2) mem[ai + 11'd1] = O_ram_data[15:8];
      end else
        I_ram_data <= (O_ram_size == 2'd1) ? {8'h00, mem[ai]} : {mem[ai + 11'd1], mem[ai]};
    end
    en_prev = O_ram_enable;
  end
  typedef struct {logic is_d; logic [15:0] data; logic err; int cyc;} exp_t;
  exp_t sb[$];
  int checks = 0, passes = 0, exp_en = 0;
  function automatic logic [71:0] outs();
    return {O_if_ack, O_if_data, O_if_err, O_d_ack, O_d_rdata, O_d_err,
            O_ram_enable, O_ram_write, O_ram_size, O_ram_addr, O_ram_data};
  endfunction
  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask
  task automatic push(input logic is_d, input logic [15:0] data, input logic err, input int at);
    sb.push_back('{is_d, data, err, at});
    if (!err) exp_en++;
  endtask
  task automatic mon();
    exp_t e;
    logic [15:0] got_data;
    logic got_err;
    if (!I_reset_n || !(O_if_ack || O_d_ack)) return;
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL unexpected_ack: got if_ack=%b d_ack=%b at cycle %0d, required no ack", O_if_ack, O_d_ack, cyc);
      return;
    end
    e = sb.pop_front();
    got_data = e.is_d ? O_d_rdata : O_if_data;
    got_err = e.is_d ? O_d_err : O_if_err;
    chk($sformatf("ack_%s_cyc%0d {d_ack,if_ack,data,err,cycle}", e.is_d ? "d" : "if", e.cyc),
        72'({O_d_ack, O_if_ack, got_data, got_err, cyc[15:0]}),
        72'({e.is_d, ~e.is_d, e.data, e.err, e.cyc[15:0]}));
  endtask
  task automatic wait_ack(input logic is_d, input string name);
    int n = 0;
    bit got = 0;
    while (!got && n < 12) begin
      @(negedge I_clk);
      n++;
      got = is_d ? O_d_ack : O_if_ack;
    end
    if (!got) begin
      checks++;
      $display("FAIL %s: got no ack within 12 cycles, required ack", name);
    end
  endtask
  task automatic if_op(input logic [15:0] a, input logic [15:0] exp_data, input logic exp_err);
    @(negedge I_clk);
    push(1'b0, exp_data, exp_err, cyc + 3);
    I_if_addr = a;
    I_if_req = 1'b1;
    wait_ack(1'b0, "if_timeout");
    I_if_req = 1'b0;
  endtask
  task automatic d_op(input logic wr, input logic [1:0] sz, input logic sg, input logic [15:0] a,
                      input logic [15:0] wd, input logic [15:0] exp_data, input logic exp_err);
    @(negedge I_clk);
    push(1'b1, exp_data, exp_err, cyc + 3);
    {I_d_write, I_d_size, I_d_signed, I_d_addr, I_d_wdata} = {wr, sz, sg, a, wd};
    I_d_req = 1'b1;
    wait_ack(1'b1, "d_timeout");
    I_d_req = 1'b0;
  endtask
  task automatic dual(input int n);
    int acks = 0, t = 0;
    I_d_req = 1'b1;
    I_if_req = 1'b1;
    while (acks < n && t < 3 * n + 6) begin
      @(negedge I_clk);
      t++;
      acks += int'(O_d_ack) + int'(O_if_ack);
    end
    I_d_req = 1'b0;
    I_if_req = 1'b0;
    if (acks < n) begin
      checks++;
      $display("FAIL dual_timeout: got %0d acks, required %0d", acks, n);
    end
  endtask
  initial begin
    fork
      forever begin
        @(negedge I_clk);
        mon();
      end
    join_none
    repeat (3) @(negedge I_clk);
    chk("reset_outputs_zero", outs(), 72'd0);
    I_reset_n = 1'b1;
    @(negedge I_clk);
    chk("idle_outputs_zero", outs(), 72'd0);
    if_op(16'h0000, 16'h8000, 1'b0);
    d_op(1'b1, 2'd1, 1'b0, 16'h0100, 16'h00A5, 16'h0000, 1'b0);
    d_op(1'b0, 2'd1, 1'b1, 16'h0100, 16'h0000, 16'hFFA5, 1'b0);
    d_op(1'b0, 2'd1, 1'b0, 16'h0100, 16'h0000, 16'h00A5, 1'b0);
    d_op(1'b1, 2'd2, 1'b0, 16'h0201, 16'h1234, 16'h00A5, 1'b0);
    d_op(1'b0, 2'd2, 1'b0, 16'h0201, 16'h0000, 16'h1234, 1'b0);
    d_op(1'b0, 2'd2, 1'b0, 16'h0800, 16'h0000, 16'h0000, 1'b1);
    d_op(1'b0, 2'd3, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b1);
    d_op(1'b0, 2'd1, 1'b0, 16'h07FF, 16'h0000, 16'h007E, 1'b0);
    if_op(16'h0900, 16'h0000, 1'b1);
    // both ports held after a fetch grant: data, fetch, data, fetch every 3 cycles
    @(negedge I_clk);
    {I_d_write, I_d_size, I_d_signed, I_d_addr, I_if_addr} = {1'b0, 2'd2, 1'b0, 16'h0201, 16'h0000};
    push(1'b1, 16'h1234, 1'b0, cyc + 3);
    push(1'b0, 16'h8000, 1'b0, cyc + 6);
    push(1'b1, 16'h1234, 1'b0, cyc + 9);
    push(1'b0, 16'h8000, 1'b0, cyc + 12);
    dual(4);
    // reset in the middle of a data access, leaving the last grant as data
    @(negedge I_clk);
    {I_d_write, I_d_size, I_d_signed, I_d_addr} = {1'b0, 2'd1, 1'b0, 16'h0100};
    I_d_req = 1'b1;
    @(posedge I_clk);
    #2;
    chk("issue_enable", 72'(O_ram_enable), 72'd1);
    I_reset_n = 1'b0;
    #1;
    chk("async_reset_zero", outs(), 72'd0);
    I_d_req = 1'b0;
    repeat (2) @(negedge I_clk);
    chk("reset_hold_zero", outs(), 72'd0);
    I_reset_n = 1'b1;
    @(negedge I_clk);
    {I_d_write, I_d_size, I_d_signed, I_d_addr, I_if_addr} = {1'b0, 2'd1, 1'b0, 16'h0100, 16'h0000};
    push(1'b1, 16'h00A5, 1'b0, cyc + 3);
    push(1'b0, 16'h8000, 1'b0, cyc + 6);
    dual(2);
    repeat (4) @(negedge I_clk);
    chk("scoreboard_drained", 72'(sb.size()), 72'd0);
    chk("ram_enable_count", 72'(en_count), 72'(exp_en));
    chk("ram_enable_single_cycle", 72'(b2b), 72'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 Parameter: ADDR_LIMIT, 16'h0800, first byte address outside RAM; requests at or above it are errors.
REQ-002 Ports: I_clk in 1, sole clock; I_reset_n in 1, asynchronous active-low reset.
REQ-003 Ports: I_if_req in 1, fetch request, level, held until ack; I_if_addr in 16, fetch address.
REQ-004 Ports: O_if_ack out 1, fetch done pulse; O_if_data out 16, fetched word; O_if_err out 1, fetch error, valid with ack.
REQ-005 Ports: I_d_req in 1, data request, level, held until ack; I_d_write in 1; I_d_size in 2, 1=byte, 2=word; I_d_signed in 1, sign-extend byte loads; I_d_addr in 16; I_d_wdata in 16.
REQ-006 Ports: O_d_ack out 1, data done pulse; O_d_rdata out 16, load result; O_d_err out 1, data error, valid with ack.
REQ-007 Ports: O_ram_enable out 1; O_ram_write out 1; O_ram_size out 2; O_ram_addr out 16; O_ram_data out 16; I_ram_data in 16, RAM read data, one-cycle registered latency.
REQ-008 One clock; reset is asynchronous and active-low: I_clk, I_reset_n.
REQ-009 All outputs SHALL be registered.

Function
REQ-010 FSM states SHALL be IDLE, ISSUE and CAPTURE.
REQ-011 IDLE: at an edge with an eligible request, latch the granted request, load RAM-side output registers and go to ISSUE; otherwise remain in IDLE with O_ram_enable=0.
REQ-012 ISSUE: O_ram_enable=1 for exactly one cycle; go to CAPTURE.
REQ-013 CAPTURE: O_ram_enable=0; at the edge, register the result and ack/err of the granted port; go to IDLE.
REQ-014 Latency: request sampled in cycle N -> ack high in cycle N+3 for exactly one cycle; maximum throughput one access per 3 cycles.
REQ-015 Handshake: a port whose ack is high in the current cycle is not eligible that cycle; the client drops or replaces its request in that cycle.
REQ-016 Arbitration: data port wins; exception: if the previous grant was data and fetch is pending, fetch wins.
REQ-017 Fetch: O_ram_write=0, O_ram_size=2; O_if_data <= I_ram_data.
REQ-018 Data byte load: O_d_rdata <= {8 x I_ram_data[7] if I_d_signed else 8'h00, I_ram_data[7:0]}.
REQ-019 Data word load: O_d_rdata <= I_ram_data; odd addresses are passed unchanged to the RAM (unaligned word permitted).
REQ-020 Stores: O_ram_write=1, O_ram_data=I_d_wdata; O_d_rdata holds its previous value.
REQ-021 Error when addr >= ADDR_LIMIT, or size not in {1,2}: no RAM enable is issued, the same 3-cycle timing is kept, ack is raised with err=1, and rdata/if_data are set to 0.
REQ-022 O_*_err SHALL be 0 on every error-free ack.
REQ-023 Requests arriving while not in IDLE SHALL wait; none are dropped.

Reset
REQ-024 Asserting I_reset_n low SHALL immediately force IDLE and drive every output to 0, including mid-ISSUE; the in-flight access is abandoned without ack.
REQ-025 After release, the first grant SHALL follow data priority; the previous-grant history resets to fetch.

Structure
REQ-026 Package cpu_mem_pkg SHALL hold the SIZE_BYTE=1 and SIZE_WORD=2 encodings, the FSM state type and the ADDR_LIMIT default.
REQ-027 Arbitration SHALL sit in sub-module mem_arbiter (inputs: eligible reqs and last grant; output: grant select).
REQ-028 The RAM side SHALL connect one-to-one to the RAM's enable/write/size/addr/data ports.

Verification
REQ-029 Word fetch from 0x0000 with the RAM bootloader preloaded -> O_if_ack at N+3 with O_if_data=16'h8000; O_if_err=0.
REQ-030 Store byte 0xA5 to 0x0100, then signed byte load from 0x0100 -> O_d_rdata=16'hFFA5; unsigned load -> 16'h00A5.
REQ-031 Fetch and data requests held continuously -> grants alternate data, fetch, data, fetch; neither port starves.
REQ-032 Data load from 0x0800, and a request with size=3 -> O_d_ack at N+3 with O_d_err=1 and O_d_rdata=0; O_ram_enable never asserted.
REQ-033 I_reset_n pulsed low during ISSUE -> all outputs 0 asynchronously, no ack; a request re-issued after release completes normally.
REQ-034 Word store 16'h1234 to odd address 0x0201, then word load from 0x0201 -> O_d_rdata=16'h1234.
